// File: rtl/pru1_led_sequencer.sv
// Avalon-MM initiator that writes an LED pattern to a 3-bit PIO, reads it back,
// and keeps a sticky mismatch flag plus a saturating error count.
module pru1_led_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [2:0]       seed,
    input  logic             clear_errors,
    input  logic             avm_waitrequest,
    input  logic [31:0]      avm_readdata,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic             avm_read_n,
    output logic [31:0]      avm_writedata,
    output logic [2:0]       pattern,
    output logic             busy,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count
);

    // state     | meaning
    // IDLE      | bus idle, waiting for enable
    // WRITE     | write pattern to PIO data register
    // READ      | read back and compare
    // WAIT_TICK | bus idle, counting TICK_DIV cycles to next update
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ      = 2'd2,
        WAIT_TICK = 2'd3
    } state_t;

    localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_t           state, state_nx;
    logic [2:0]       pattern_nx;
    logic [CNT_W-1:0] tick_cnt, tick_nx;
    logic             stop_pend, stop_nx;
    logic             mismatch_nx;
    logic [ERR_W-1:0] err_nx;
    logic             unused_rdata;

    assign unused_rdata  = ^avm_readdata[31:3];
    assign avm_address   = 2'b00;
    assign avm_writedata = {29'b0, pattern};

    function automatic logic [2:0] start_pattern(input logic [1:0] m, input logic [2:0] s);
        case (m)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b101;
            default: return s;
        endcase
    endfunction

    function automatic logic [2:0] advance_pattern(input logic [1:0] m, input logic [2:0] p,
                                                   input logic [2:0] s);
        case (m)
            2'd0:    return p + 3'd1;
            2'd1:    return (p == 3'b001) ? 3'b010 : (p == 3'b010) ? 3'b100 : 3'b001;
            2'd2:    return (p == 3'b101) ? 3'b010 : 3'b101;
            default: return s;
        endcase
    endfunction

    always_comb begin
        state_nx       = state;
        pattern_nx     = pattern;
        tick_nx        = tick_cnt;
        stop_nx        = stop_pend;
        mismatch_nx    = mismatch;
        err_nx         = err_count;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_read_n     = 1'b1;

        case (state)
            IDLE: begin
                stop_nx = 1'b0;
                if (enable) begin
                    pattern_nx = start_pattern(mode, seed);
                    state_nx   = WRITE;
                end
            end
            WRITE: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                if (!enable) stop_nx = 1'b1;
                if (!avm_waitrequest) state_nx = READ;
            end
            READ: begin
                avm_chipselect = 1'b1;
                avm_read_n     = 1'b0;
                if (!enable) stop_nx = 1'b1;
                if (!avm_waitrequest) begin
                    if (avm_readdata[2:0] != pattern) begin
                        mismatch_nx = 1'b1;
                        if (err_count != ERR_MAX) err_nx = err_count + ERR_W'(1);
                    end
                    tick_nx = '0;
                    // A disable seen during the transfer skips the tick wait.
                    state_nx = (stop_pend || !enable) ? IDLE : WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (tick_cnt == TICK_LAST) begin
                    pattern_nx = advance_pattern(mode, pattern, seed);
                    state_nx   = WRITE;
                end else begin
                    tick_nx = tick_cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        if (clear_errors) begin
            mismatch_nx = 1'b0;
            err_nx      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pattern   <= 3'b000;
            tick_cnt  <= '0;
            stop_pend <= 1'b0;
            busy      <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            pattern   <= pattern_nx;
            tick_cnt  <= tick_nx;
            stop_pend <= stop_nx;
            busy      <= (state_nx != IDLE);
            mismatch  <= mismatch_nx;
            err_count <= err_nx;
        end
    end

endmodule

// File: tb/tb_pru1_led_sequencer.sv
// Bench for pru1_led_sequencer: echo PIO slave with optional read corruption,
// transaction-level model checked every cycle, plus directed literal checks.
module tb_pru1_led_sequencer;

    localparam int TICK_DIV = 4;
    localparam int ERR_W    = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [2:0]       seed = 3'd0;
    logic             clear_errors = 1'b0;
    logic             avm_waitrequest = 1'b0;
    logic [31:0]      avm_readdata;
    logic [1:0]       avm_address;
    logic             avm_chipselect;
    logic             avm_write_n;
    logic             avm_read_n;
    logic [31:0]      avm_writedata;
    logic [2:0]       pattern;
    logic             busy;
    logic             mismatch;
    logic [ERR_W-1:0] err_count;

    pru1_led_sequencer #(.TICK_DIV(TICK_DIV), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .seed(seed),
        .clear_errors(clear_errors), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_address(avm_address),
        .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
        .avm_read_n(avm_read_n), .avm_writedata(avm_writedata), .pattern(pattern),
        .busy(busy), .mismatch(mismatch), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Echo slave; rd_and / rd_xor corrupt the low bits of read-back data.
    logic [2:0] mem = 3'd0;
    logic [2:0] rd_and = 3'b111;
    logic [2:0] rd_xor = 3'b000;
    int         accepted = 0;
    assign avm_readdata = {29'h0BADCAFE, (mem & rd_and) ^ rd_xor};
    always @(posedge clk)
        if (avm_chipselect && !avm_write_n && !avm_waitrequest) begin
            mem      <= avm_writedata[2:0];
            accepted <= accepted + 1;
        end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [2:0] init_pat(input logic [1:0] m, input logic [2:0] s);
        case (m)
            2'd0: return 3'd0;
            2'd1: return 3'd1;
            2'd2: return 3'd5;
            default: return s;
        endcase
    endfunction

    function automatic logic [2:0] adv_pat(input logic [1:0] m, input logic [2:0] p,
                                           input logic [2:0] s);
        int v;
        v = int'(p);
        case (m)
            2'd0: return 3'((v + 1) % 8);
            2'd1: return (v == 1) ? 3'd2 : (v == 2) ? 3'd4 : 3'd1;
            2'd2: return (v == 5) ? 3'd2 : 3'd5;
            default: return s;
        endcase
    endfunction

    // Model: next write is the start pattern if enable was low at any sampled
    // cycle since the previous write began (or after reset), otherwise an advance.
    bit               started = 0;
    int               cycle = 0;
    int               wr_starts = 0;
    int               wr_log[$];
    int               wr_cycle[$];
    logic [2:0]       m_pat = 3'd0;
    logic             m_mis = 1'b0;
    logic [ERR_W-1:0] m_err = '0;
    bit               en_low = 1, prev_pend = 0, stall_seen = 0;
    logic [1:0]       mode_q = 2'd0;
    logic [2:0]       seed_q = 3'd0;

    always @(negedge clk) begin
        logic [2:0] exp_p;
        bit         fresh;
        cycle++;
        if (started) begin
            if (avm_chipselect && !avm_write_n && !prev_pend) begin
                fresh = en_low;
                exp_p = fresh ? init_pat(mode_q, seed_q) : adv_pat(mode_q, m_pat, seed_q);
                check("write_pattern", {29'b0, avm_writedata[2:0]}, {29'b0, exp_p});
                if (!fresh && !stall_seen && wr_cycle.size() > 0)
                    check("write_spacing", cycle - wr_cycle[$], TICK_DIV + 2);
                m_pat      = exp_p;
                en_low     = !enable;
                stall_seen = 0;
                wr_starts++;
                wr_log.push_back(int'(avm_writedata[2:0]));
                wr_cycle.push_back(cycle);
            end else if (!enable) begin
                en_low = 1;
            end
            check("address", {30'b0, avm_address}, 0);
            check("writedata_hi", {3'b0, avm_writedata[31:3]}, 0);
            check("pattern", {29'b0, pattern}, {29'b0, m_pat});
            check("mismatch", {31'b0, mismatch}, {31'b0, m_mis});
            check("err_count", 32'(err_count), 32'(m_err));
            if (avm_chipselect) begin
                check("busy_in_xfer", {31'b0, busy}, 1);
                check("one_strobe", {31'b0, avm_write_n ^ avm_read_n}, 1);
            end else begin
                check("strobes_idle", {30'b0, avm_write_n, avm_read_n}, 3);
            end
            if (avm_chipselect && !avm_write_n)
                check("write_hold", {29'b0, avm_writedata[2:0]}, {29'b0, m_pat});
            if (avm_chipselect && avm_waitrequest) stall_seen = 1;
            prev_pend = avm_chipselect && !avm_write_n && avm_waitrequest;
            if (avm_chipselect && !avm_read_n && !avm_waitrequest &&
                avm_readdata[2:0] != m_pat) begin
                m_mis = 1'b1;
                if (m_err != '1) m_err = m_err + 1'b1;
            end
            if (clear_errors) begin
                m_mis = 1'b0;
                m_err = '0;
            end
        end
        if (reset) begin
            m_pat = 3'd0; m_mis = 1'b0; m_err = '0;
            en_low = 1; prev_pend = 0; stall_seen = 0;
        end
        mode_q = mode;
        seed_q = seed;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
    endtask

    task automatic wait_writes(input int n);
        int budget = 400;
        while (wr_starts < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("wait_writes", {31'b0, wr_starts >= n}, 1);
    endtask

    int base, base2, acc0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        started = 1;
        peek();
        check("rst_cs", {31'b0, avm_chipselect}, 0);
        check("rst_write_n", {31'b0, avm_write_n}, 1);
        check("rst_read_n", {31'b0, avm_read_n}, 1);
        check("rst_writedata", avm_writedata, 0);
        check("rst_pattern", {29'b0, pattern}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_mismatch", {31'b0, mismatch}, 0);
        check("rst_err", 32'(err_count), 0);

        // Count-up
        step(); mode = 2'd0; enable = 1'b1; base = wr_starts;
        wait_writes(base + 9);
        for (int i = 0; i < 9; i++) check("count_up_seq", wr_log[base + i], i % 8);
        check("count_up_gap_a", wr_cycle[base + 1] - wr_cycle[base], 6);
        check("count_up_gap_b", wr_cycle[base + 8] - wr_cycle[base + 7], 6);
        step(); enable = 1'b0;
        repeat (3) step();
        peek();
        check("count_up_mismatch", {31'b0, mismatch}, 0);
        check("count_up_err", 32'(err_count), 0);
        check("disable_idle_busy", {31'b0, busy}, 0);

        // Walking one, then mode 2 switched in WAIT_TICK after 010
        step(); mode = 2'd1; enable = 1'b1; base = wr_starts;
        wait_writes(base + 2);
        step(); mode = 2'd2;
        wait_writes(base + 4);
        check("walk_0", wr_log[base], 1);
        check("walk_1", wr_log[base + 1], 2);
        check("walk_mode2_a", wr_log[base + 2], 5);
        check("walk_mode2_b", wr_log[base + 3], 2);
        step(); enable = 1'b0;
        repeat (3) step();

        // Write stall: 3 stalled cycles, then completion
        step(); mode = 2'd3; seed = 3'b110; avm_waitrequest = 1'b1; enable = 1'b1;
        acc0 = accepted; base = wr_starts;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) avm_waitrequest = 1'b0;
            peek();
            check("stall_cs", {31'b0, avm_chipselect}, 1);
            check("stall_write_n", {31'b0, avm_write_n}, 0);
            check("stall_writedata", avm_writedata, 32'd6);
        end
        step(); peek();
        check("stall_read_n", {31'b0, avm_read_n}, 0);
        check("stall_read_write_n", {31'b0, avm_write_n}, 1);
        step(); peek();
        check("stall_one_accept", accepted - acc0, 1);
        check("stall_one_start", wr_starts - base, 1);
        enable = 1'b0;
        repeat (3) step();

        // Read-back error: bit1 forced low
        mode = 2'd0; rd_and = 3'b101; enable = 1'b1; base = wr_starts;
        wait_writes(base + 2);
        step(); peek();
        check("rb_before_2_mis", {31'b0, mismatch}, 0);
        wait_writes(base + 3);
        step(); peek();
        check("rb_at_2_mis", {31'b0, mismatch}, 1);
        check("rb_at_2_err", 32'(err_count), 1);
        wait_writes(base + 8);
        step(); peek();
        check("rb_after_7_err", 32'(err_count), 4);
        check("rb_after_7_mis", {31'b0, mismatch}, 1);
        step(); clear_errors = 1'b1;
        step(); clear_errors = 1'b0;
        peek();
        check("clear_mis", {31'b0, mismatch}, 0);
        check("clear_err", 32'(err_count), 0);
        wait_writes(base + 11);
        #1 clear_errors = 1'b1;
        step(); clear_errors = 1'b0;
        peek();
        check("clear_coincident_mis", {31'b0, mismatch}, 0);
        check("clear_coincident_err", 32'(err_count), 0);
        step(); rd_xor = 3'b111; base2 = wr_starts;
        wait_writes(base2 + 9);
        step(); peek();
        check("err_saturate", 32'(err_count), 7);
        step(); enable = 1'b0; rd_xor = 3'b000; rd_and = 3'b111;
        step(); clear_errors = 1'b1;
        step(); clear_errors = 1'b0;
        repeat (2) step();

        // Disable mid-write with a 2-cycle stall
        mode = 2'd0; enable = 1'b1; base = wr_starts;
        wait_writes(base + 2);
        #1;
        repeat (4) step();
        avm_waitrequest = 1'b1;
        step(); enable = 1'b0;
        peek();
        check("dis_write_n", {31'b0, avm_write_n}, 0);
        check("dis_writedata", avm_writedata, 32'd2);
        step();
        step(); avm_waitrequest = 1'b0;
        peek();
        check("dis_write_done", {31'b0, avm_write_n}, 0);
        step(); peek();
        check("dis_read_cs", {31'b0, avm_chipselect}, 1);
        check("dis_read_n", {31'b0, avm_read_n}, 0);
        step(); peek();
        check("dis_idle_cs", {31'b0, avm_chipselect}, 0);
        check("dis_idle_busy", {31'b0, busy}, 0);
        check("dis_pattern", {29'b0, pattern}, 2);
        repeat (3) step();
        peek();
        check("dis_still_idle", {31'b0, busy}, 0);
        check("dis_pattern_kept", {29'b0, pattern}, 2);
        check("dis_no_more_writes", wr_starts - base, 3);

        // Re-enable reloads 000; then reset during a read
        step(); rd_xor = 3'b111; enable = 1'b1;
        wait_writes(base + 4);
        check("reenable_first", wr_log[base + 3], 0);
        wait_writes(base + 5);
        #1 reset = 1'b1;
        peek();
        check("pre_reset_read_n", {31'b0, avm_read_n}, 0);
        check("pre_reset_err", 32'(err_count), 1);
        step(); reset = 1'b0;
        peek();
        check("post_reset_cs", {31'b0, avm_chipselect}, 0);
        check("post_reset_read_n", {31'b0, avm_read_n}, 1);
        check("post_reset_busy", {31'b0, busy}, 0);
        check("post_reset_err", 32'(err_count), 0);
        check("post_reset_pattern", {29'b0, pattern}, 0);
        step(); step(); enable = 1'b0; rd_xor = 3'b000;
        repeat (5) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
